// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Initiator side of the byte-addressed data/instruction RAM port. Accepts one
// load64 / store64 / ifetch80 request over a valid/ready handshake, drives the
// RAM for exactly one access cycle, and returns a registered response that is
// held until the consumer accepts it. Out-of-range and reserved requests never
// enable the RAM. A store whose access cycle coincides with reset never
// reaches the RAM either.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_valid_i/req_ready_o   request handshake
//   req_op_i                  00 load64, 01 store64, 10 ifetch80, 11 reserved
//   req_addr_i, req_wdata_i   byte address, little-endian store data
//   resp_valid_o/resp_ready_i response handshake
//   resp_rdata_o              load data (0 for store/ifetch/error)
//   resp_instr_o              fetched instruction (0 for load/store/error)
//   resp_error_o              transaction faulted
//   err_count_o               saturating count of faulted transactions
//   mem_*                     RAM side: address, enables, write data,
//                             combinational read data and error flag
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [63:0]      req_addr_i,
    input  logic [63:0]      req_wdata_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [63:0]      resp_rdata_o,
    output logic [79:0]      resp_instr_o,
    output logic             resp_error_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [63:0]      mem_addr_o,
    output logic             mem_read_en_o,
    output logic             mem_write_en_o,
    output logic             mem_read_instruction_o,
    output logic [63:0]      mem_write_data_o,
    input  logic [63:0]      mem_read_data_i,
    input  logic [79:0]      mem_read_instruction_i,
    input  logic             mem_error_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_FETCH = 2'b10;

    // Highest legal start address for an 8-byte and a 10-byte access.
    localparam logic [63:0] LAST_ADDR8  = 64'(MEM_BYTES) - 64'd8;
    localparam logic [63:0] LAST_ADDR10 = 64'(MEM_BYTES) - 64'd10;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [63:0]       addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [63:0]       resp_rdata_q, resp_rdata_d;
    logic [79:0]       resp_instr_q, resp_instr_d;
    logic              resp_error_q, resp_error_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;

    logic              fault_s;
    logic              err_s;

    // Local fault: reserved opcode or access running past the end of RAM.
    // Comparing against MEM_BYTES-size avoids 64-bit wrap of addr+size.
    always_comb begin
        case (op_q)
            OP_LOAD,
            OP_STORE: fault_s = (addr_q > LAST_ADDR8);
            OP_FETCH: fault_s = (addr_q > LAST_ADDR10);
            default:  fault_s = 1'b1;
        endcase
    end

    assign err_s = fault_s || mem_error_i;

    assign req_ready_o      = (state_q == ST_IDLE) && !rst_i;
    assign mem_addr_o       = addr_q;
    assign mem_write_data_o = wdata_q;

    // RAM enables, active only during the single access cycle.
    always_comb begin
        mem_read_en_o          = 1'b0;
        mem_write_en_o         = 1'b0;
        mem_read_instruction_o = 1'b0;
        if (state_q == ST_ACCESS) begin
            case (op_q)
                OP_LOAD: begin
                    mem_read_en_o = !fault_s;
                end
                OP_STORE: begin
                    // rst_i gate keeps a reset-coincident store out of the RAM.
                    mem_write_en_o = !fault_s && !mem_error_i && !rst_i;
                end
                OP_FETCH: begin
                    mem_read_en_o          = !fault_s;
                    mem_read_instruction_o = !fault_s;
                end
                default: begin
                    mem_read_en_o = 1'b0;
                end
            endcase
        end else begin
            mem_read_en_o = 1'b0;
        end
    end

    // Next-state and response capture.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_instr_d = resp_instr_q;
        resp_error_d = resp_error_q;
        err_count_d  = err_count_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    op_d    = req_op_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                resp_valid_d = 1'b1;
                resp_error_d = err_s;
                resp_rdata_d = (op_q == OP_LOAD  && !err_s) ? mem_read_data_i        : 64'd0;
                resp_instr_d = (op_q == OP_FETCH && !err_s) ? mem_read_instruction_i : 80'd0;
                if (err_s && (err_count_q != {CNT_W{1'b1}})) begin
                    err_count_d = err_count_q + CNT_W'(1);
                end else begin
                    err_count_d = err_count_q;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and response registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            op_q         <= 2'd0;
            addr_q       <= 64'd0;
            wdata_q      <= 64'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 64'd0;
            resp_instr_q <= 80'd0;
            resp_error_q <= 1'b0;
            err_count_q  <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_instr_q <= resp_instr_d;
            resp_error_q <= resp_error_d;
            err_count_q  <= err_count_d;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_instr_o = resp_instr_q;
    assign resp_error_o = resp_error_q;
    assign err_count_o  = err_count_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for mem_access_ctrl. A byte-array RAM model sits on the memory
// port; a separate byte-array reference model predicts every response from
// the access rules (size, bounds, error flag, little-endian byte order).
// A second instance with a 3-bit error counter shares all inputs so counter
// saturation can be reached in a handful of transactions.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic [1:0]  req_op_i = 2'd0;
    logic [63:0] req_addr_i = 64'd0;
    logic [63:0] req_wdata_i = 64'd0;
    logic        resp_ready_i = 1'b0;
    logic        mem_error_i = 1'b0;
    logic [63:0] mem_read_data_i;
    logic [79:0] mem_read_instruction_i;

    logic        req_ready_o, resp_valid_o, resp_error_o;
    logic [63:0] resp_rdata_o;
    logic [79:0] resp_instr_o;
    logic [15:0] err_count_o;
    logic [63:0] mem_addr_o, mem_write_data_o;
    logic        mem_read_en_o, mem_write_en_o, mem_read_instruction_o;

    logic        s_req_ready, s_resp_valid, s_resp_error;
    logic [63:0] s_resp_rdata;
    logic [79:0] s_resp_instr;
    logic [2:0]  s_err_count;
    logic [63:0] s_mem_addr, s_mem_wdata;
    logic        s_mem_rd, s_mem_wr, s_mem_ri;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_BYTES(1024), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_instr_o(resp_instr_o),
        .resp_error_o(resp_error_o), .err_count_o(err_count_o),
        .mem_addr_o(mem_addr_o), .mem_read_en_o(mem_read_en_o),
        .mem_write_en_o(mem_write_en_o), .mem_read_instruction_o(mem_read_instruction_o),
        .mem_write_data_o(mem_write_data_o), .mem_read_data_i(mem_read_data_i),
        .mem_read_instruction_i(mem_read_instruction_i), .mem_error_i(mem_error_i)
    );

    mem_access_ctrl #(.MEM_BYTES(1024), .CNT_W(3)) dut_small (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(s_req_ready),
        .req_op_i(req_op_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .resp_valid_o(s_resp_valid), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(s_resp_rdata), .resp_instr_o(s_resp_instr),
        .resp_error_o(s_resp_error), .err_count_o(s_err_count),
        .mem_addr_o(s_mem_addr), .mem_read_en_o(s_mem_rd),
        .mem_write_en_o(s_mem_wr), .mem_read_instruction_o(s_mem_ri),
        .mem_write_data_o(s_mem_wdata), .mem_read_data_i(mem_read_data_i),
        .mem_read_instruction_i(mem_read_instruction_i), .mem_error_i(mem_error_i)
    );

    // ---------------- RAM environment model ----------------
    bit [7:0] ram [1024];
    int       wr_pulses = 0;

    always_comb begin
        mem_read_data_i        = 64'd0;
        mem_read_instruction_i = 80'd0;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] b;
            if (mem_addr_o + 64'(i) < 64'd1024) b = ram[10'(mem_addr_o + 64'(i))];
            else                                b = 8'hA5;
            if (i < 8) mem_read_data_i[8*i +: 8] = b;
            mem_read_instruction_i[8*i +: 8] = b;
        end
    end

    always @(posedge clk) begin
        if (mem_write_en_o) begin
            wr_pulses <= wr_pulses + 1;
            for (int i = 0; i < 8; i++) begin
                if (mem_addr_o + 64'(i) < 64'd1024)
                    ram[10'(mem_addr_o + 64'(i))] <= mem_write_data_o[8*i +: 8];
            end
        end
    end

    // ---------------- reference model ----------------
    bit [7:0]    ref_mem [1024];
    int unsigned exp_cnt = 0;
    int unsigned exp_cnt_s = 0;
    int          checks = 0;
    int          failures = 0;
    logic [63:0] last_rdata;
    logic [79:0] last_instr;
    logic        last_error;

    // One full transaction: accept, access cycle, response, optional stall.
    task automatic do_txn(input logic [1:0] op, input logic [63:0] addr,
                          input logic [63:0] wd, input bit inj, input int stall);
        int          size;
        bit          fault, err, exp_wr, exp_rd, exp_ri;
        logic [63:0] exp_rdata;
        logic [79:0] exp_instr;
        int          wr0;
        int          guard;

        size   = (op == 2'b10) ? 10 : 8;
        fault  = (op == 2'b11) || ({1'b0, addr} + 65'(size) > 65'd1024);
        err    = fault || inj;
        exp_rd = !fault && (op == 2'b00 || op == 2'b10);
        exp_ri = !fault && (op == 2'b10);
        exp_wr = !fault && !inj && (op == 2'b01);
        exp_rdata = 64'd0;
        exp_instr = 80'd0;
        if (!err && op == 2'b00)
            for (int i = 0; i < 8; i++) exp_rdata[8*i +: 8] = ref_mem[10'(addr + 64'(i))];
        if (!err && op == 2'b10)
            for (int i = 0; i < 10; i++) exp_instr[8*i +: 8] = ref_mem[10'(addr + 64'(i))];
        if (exp_wr)
            for (int i = 0; i < 8; i++) ref_mem[10'(addr + 64'(i))] = wd[8*i +: 8];
        if (err) begin
            if (exp_cnt < 32'hFFFF) exp_cnt++;
            if (exp_cnt_s < 7) exp_cnt_s++;
        end

        guard = 0;
        while (!req_ready_o && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        checks++;
        if (req_ready_o !== 1'b1) begin
            failures++; $display("FAIL ready_timeout got=%b want=1", req_ready_o);
        end

        req_valid_i = 1'b1; req_op_i = op; req_addr_i = addr; req_wdata_i = wd;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        req_op_i = 2'(($urandom));
        req_addr_i = {$urandom, $urandom};
        req_wdata_i = {$urandom, $urandom};
        mem_error_i = inj;
        #1;
        // Access cycle
        checks++;
        if ({mem_read_en_o, mem_read_instruction_o, mem_write_en_o} !== {exp_rd, exp_ri, exp_wr}) begin
            failures++;
            $display("FAIL access_enables op=%0d addr=%0h got rd/ri/wr=%b%b%b want=%b%b%b",
                     op, addr, mem_read_en_o, mem_read_instruction_o, mem_write_en_o,
                     exp_rd, exp_ri, exp_wr);
        end
        checks++;
        if (mem_addr_o !== addr || mem_write_data_o !== wd) begin
            failures++;
            $display("FAIL access_addr_data got=%0h/%0h want=%0h/%0h",
                     mem_addr_o, mem_write_data_o, addr, wd);
        end
        checks++;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL access_handshake got valid=%b ready=%b want 0 0", resp_valid_o, req_ready_o);
        end
        wr0 = wr_pulses;
        @(posedge clk); #1;
        mem_error_i = 1'b0;

        // Response phase (two cycles after acceptance)
        checks++;
        if (wr_pulses - wr0 !== (exp_wr ? 1 : 0)) begin
            failures++; $display("FAIL write_pulses got=%0d want=%0d", wr_pulses - wr0, exp_wr);
        end
        for (int k = 0; k <= stall; k++) begin
            checks++;
            if (resp_valid_o !== 1'b1 || resp_error_o !== err || resp_rdata_o !== exp_rdata ||
                resp_instr_o !== exp_instr || req_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL resp_fields cyc=%0d got v=%b e=%b rd=%0h in=%0h rdy=%b want v=1 e=%b rd=%0h in=%0h rdy=0",
                         k, resp_valid_o, resp_error_o, resp_rdata_o, resp_instr_o, req_ready_o,
                         err, exp_rdata, exp_instr);
            end
            checks++;
            if (err_count_o !== 16'(exp_cnt) || s_err_count !== 3'(exp_cnt_s)) begin
                failures++;
                $display("FAIL err_count got=%0h/%0h want=%0h/%0h",
                         err_count_o, s_err_count, exp_cnt, exp_cnt_s);
            end
            if (k < stall) begin
                // A competing request during backpressure must be ignored.
                req_valid_i = 1'b1; req_op_i = 2'b01; req_addr_i = 64'h8; req_wdata_i = 64'hFFFF;
                @(posedge clk); #1;
                req_valid_i = 1'b0;
            end
        end
        last_rdata = resp_rdata_o;
        last_instr = resp_instr_o;
        last_error = resp_error_o;

        resp_ready_i = 1'b1;
        @(posedge clk); #1;
        resp_ready_i = 1'b0;
        checks++;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL resp_release got valid=%b ready=%b want 0 1", resp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready_o !== 1'b0) begin
            failures++; $display("FAIL reset_ready_low got=%b want=0", req_ready_o);
        end
        @(posedge clk); #1;
        rst_i = 1'b0;
        #1;
        checks++;
        if (resp_valid_o !== 1'b0 || resp_rdata_o !== 64'd0 || resp_instr_o !== 80'd0 ||
            resp_error_o !== 1'b0 || err_count_o !== 16'd0 || req_ready_o !== 1'b1 ||
            mem_read_en_o !== 1'b0 || mem_write_en_o !== 1'b0 || mem_addr_o !== 64'd0) begin
            failures++;
            $display("FAIL reset_state got v=%b rd=%0h in=%0h e=%b cnt=%0h rdy=%b addr=%0h want 0s and rdy=1",
                     resp_valid_o, resp_rdata_o, resp_instr_o, resp_error_o, err_count_o,
                     req_ready_o, mem_addr_o);
        end
        exp_cnt = 0; exp_cnt_s = 0;
    endtask

    task automatic test_store_load();
        do_txn(2'b01, 64'h10, 64'h1122334455667788, 1'b0, 0);
        do_txn(2'b00, 64'h10, 64'h0, 1'b0, 0);
        checks++;
        if (last_rdata !== 64'h1122334455667788 || last_error !== 1'b0) begin
            failures++;
            $display("FAIL store_load got=%0h err=%b want=1122334455667788 err=0", last_rdata, last_error);
        end
    endtask

    task automatic test_ifetch();
        do_txn(2'b01, 64'h20, 64'h0706050403020100, 1'b0, 0);
        do_txn(2'b01, 64'h28, 64'h0F0E0D0C0B0A0908, 1'b0, 0);
        do_txn(2'b10, 64'h20, 64'h0, 1'b0, 0);
        checks++;
        if (last_instr !== 80'h09080706050403020100) begin
            failures++; $display("FAIL ifetch got=%0h want=09080706050403020100", last_instr);
        end
    endtask

    task automatic test_bounds();
        do_txn(2'b00, 64'd1016, 64'h0, 1'b0, 0);
        checks++;
        if (last_error !== 1'b0) begin
            failures++; $display("FAIL load_1016 got err=%b want=0", last_error);
        end
        do_txn(2'b01, 64'd1017, 64'hCAFEF00DCAFEF00D, 1'b0, 0);
        checks++;
        if (last_error !== 1'b1 || err_count_o !== 16'd1) begin
            failures++; $display("FAIL store_1017 got err=%b cnt=%0d want err=1 cnt=1", last_error, err_count_o);
        end
        do_txn(2'b10, 64'd1014, 64'h0, 1'b0, 0);
        do_txn(2'b10, 64'd1015, 64'h0, 1'b0, 0);
        checks++;
        if (last_error !== 1'b1 || last_instr !== 80'd0) begin
            failures++; $display("FAIL ifetch_1015 got err=%b instr=%0h want err=1 instr=0", last_error, last_instr);
        end
        do_txn(2'b01, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1234, 1'b0, 0);
        do_txn(2'b00, 64'h100, 64'h0, 1'b1, 0);
        do_txn(2'b01, 64'h100, 64'h5555, 1'b1, 0);
    endtask

    task automatic test_backpressure();
        do_txn(2'b00, 64'h10, 64'h0, 1'b0, 5);
        do_txn(2'b10, 64'h20, 64'h0, 1'b0, 3);
    endtask

    task automatic test_reserved();
        do_txn(2'b11, 64'h0, 64'h0, 1'b0, 0);
        checks++;
        if (last_error !== 1'b1 || last_rdata !== 64'd0) begin
            failures++; $display("FAIL reserved_op got err=%b rd=%0h want err=1 rd=0", last_error, last_rdata);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 8; i++) do_txn(2'b11, 64'(i), 64'h0, 1'b0, 0);
        checks++;
        if (s_err_count !== 3'h7) begin
            failures++; $display("FAIL counter_saturate got=%0h want=7", s_err_count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [1:0]  op;
            logic [63:0] addr;
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) addr = {$urandom, $urandom};
            else                           addr = 64'($urandom_range(0, 1030));
            do_txn(op, addr, {$urandom, $urandom}, ($urandom_range(0, 7) == 0),
                   int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_reset_mid();
        req_valid_i = 1'b1; req_op_i = 2'b01; req_addr_i = 64'h40; req_wdata_i = 64'hDEADBEEF;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        checks++;
        if (mem_write_en_o !== 1'b0) begin
            failures++; $display("FAIL reset_store_wen got=%b want=0", mem_write_en_o);
        end
        @(posedge clk); #1;
        rst_i = 1'b0;
        exp_cnt = 0; exp_cnt_s = 0;
        #1;
        checks++;
        if (resp_valid_o !== 1'b0 || err_count_o !== 16'd0 || s_err_count !== 3'd0 || req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_state got v=%b cnt=%0h/%0h rdy=%b want 0 0/0 1",
                     resp_valid_o, err_count_o, s_err_count, req_ready_o);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ram[10'(64'h40 + 64'(i))] !== ref_mem[10'(64'h40 + 64'(i))]) begin
                failures++;
                $display("FAIL reset_ram_unchanged byte=%0d got=%0h want=%0h",
                         i, ram[10'(64'h40 + 64'(i))], ref_mem[10'(64'h40 + 64'(i))]);
            end
        end
        // Pending response dropped by reset.
        do_txn(2'b00, 64'h50, 64'h0, 1'b0, 2);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        #1;
        checks++;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            failures++; $display("FAIL reset_idle got v=%b rdy=%b want 0 1", resp_valid_o, req_ready_o);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_ifetch();
        test_bounds();
        test_backpressure();
        test_reserved();
        test_saturation();
        test_random();
        test_reset_mid();
        // Full memory image must match the reference after all traffic.
        for (int a = 0; a < 1024; a++) begin
            if (ram[a] !== ref_mem[a]) begin
                checks++; failures++;
                $display("FAIL ram_image addr=%0h got=%0h want=%0h", a, ram[a], ref_mem[a]);
            end
        end
        checks++;
        if (wr_pulses == 0) begin
            failures++; $display("FAIL write_activity got=0 want>0");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=timeout want=finish");
        $fatal(1, "timeout");
    end

endmodule
